// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational ALU: arbitrate, latch operands, capture result, hand it back.
// Accept at T gives response valid at T+2; each operation occupies at least 3 cycles.
module alu_arbiter #(
   parameter int FIXED_PRI = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic [3:0]  req0_cmd,
   input  logic [1:0]  req0_aluop,
   input  logic        req0_branch,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   input  logic [3:0]  req1_cmd,
   input  logic [1:0]  req1_aluop,
   input  logic        req1_branch,
   output logic        rsp0_valid,
   input  logic        rsp0_ready,
   output logic [31:0] rsp0_data,
   output logic        rsp0_flag,
   output logic        rsp1_valid,
   input  logic        rsp1_ready,
   output logic [31:0] rsp1_data,
   output logic        rsp1_flag,
   output logic [31:0] alu_in1,
   output logic [31:0] alu_in2,
   output logic [3:0]  alu_ex_cmd,
   output logic [1:0]  alu_aluop,
   output logic        alu_branchD,
   input  logic [31:0] alu_out,
   input  logic        alu_flag,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t      state;
   logic        last_grant;
   logic        owner;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [3:0]  op_cmd;
   logic [1:0]  op_aluop;
   logic        op_branch;
   logic [31:0] res_data;
   logic        res_flag;

   logic        any_req;
   logic        win;
   logic        accept;
   logic        owner_ready;

   always_comb begin
      any_req = req0_valid | req1_valid;
      if (req0_valid && req1_valid)
         win = (FIXED_PRI != 0) ? 1'b0 : ~last_grant;
      else
         win = req1_valid;
      // Reset gating keeps the grant low while rst_n is held, even with requests pending.
      accept      = rst_n & (state == IDLE) & any_req;
      req0_ready  = accept & ~win;
      req1_ready  = accept & win;
      owner_ready = owner ? rsp1_ready : rsp0_ready;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         owner      <= 1'b0;
         op_a       <= '0;
         op_b       <= '0;
         op_cmd     <= '0;
         op_aluop   <= '0;
         op_branch  <= 1'b0;
         res_data   <= '0;
         res_flag   <= 1'b0;
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  op_a       <= win ? req1_a      : req0_a;
                  op_b       <= win ? req1_b      : req0_b;
                  op_cmd     <= win ? req1_cmd    : req0_cmd;
                  op_aluop   <= win ? req1_aluop  : req0_aluop;
                  op_branch  <= win ? req1_branch : req0_branch;
                  owner      <= win;
                  last_grant <= win;
                  busy       <= 1'b1;
                  state      <= EXEC;
               end
            end
            EXEC: begin
               res_data   <= alu_out;
               res_flag   <= alu_flag;
               rsp0_valid <= ~owner;
               rsp1_valid <= owner;
               state      <= RESP;
            end
            RESP: begin
               if (owner_ready) begin
                  rsp0_valid <= 1'b0;
                  rsp1_valid <= 1'b0;
                  busy       <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign rsp0_data   = res_data;
   assign rsp0_flag   = res_flag;
   assign rsp1_data   = res_data;
   assign rsp1_flag   = res_flag;
   assign alu_in1     = op_a;
   assign alu_in2     = op_b;
   assign alu_ex_cmd  = op_cmd;
   assign alu_aluop   = op_aluop;
   assign alu_branchD = op_branch;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: round-robin and fixed-priority instances share stimulus and are checked against a transaction-level model.
module tb_alu_arbiter;

   logic        clk;
   logic        rst_n;
   logic        v0, v1, br0, br1, rr0, rr1;
   logic [31:0] a0, b0, a1, b1;
   logic [3:0]  c0, c1;
   logic [1:0]  op0, op1;

   logic [1:0]  o_rdy0, o_rdy1, o_rv0, o_rv1, o_rf0, o_rf1, o_br, o_busy, alu_f;
   logic [31:0] o_rd0 [2];
   logic [31:0] o_rd1 [2];
   logic [31:0] o_in1 [2];
   logic [31:0] o_in2 [2];
   logic [31:0] alu_o [2];
   logic [3:0]  o_cmd [2];
   logic [1:0]  o_op  [2];

   int checks = 0;
   int errors = 0;

   genvar g;
   for (g = 0; g < 2; g++) begin : g_dut
      alu_arbiter #(.FIXED_PRI(g)) u (
         .clk(clk), .rst_n(rst_n),
         .req0_valid(v0), .req0_ready(o_rdy0[g]), .req0_a(a0), .req0_b(b0),
         .req0_cmd(c0), .req0_aluop(op0), .req0_branch(br0),
         .req1_valid(v1), .req1_ready(o_rdy1[g]), .req1_a(a1), .req1_b(b1),
         .req1_cmd(c1), .req1_aluop(op1), .req1_branch(br1),
         .rsp0_valid(o_rv0[g]), .rsp0_ready(rr0), .rsp0_data(o_rd0[g]), .rsp0_flag(o_rf0[g]),
         .rsp1_valid(o_rv1[g]), .rsp1_ready(rr1), .rsp1_data(o_rd1[g]), .rsp1_flag(o_rf1[g]),
         .alu_in1(o_in1[g]), .alu_in2(o_in2[g]), .alu_ex_cmd(o_cmd[g]),
         .alu_aluop(o_op[g]), .alu_branchD(o_br[g]),
         .alu_out(alu_o[g]), .alu_flag(alu_f[g]), .busy(o_busy[g])
      );
      assign alu_o[g] = o_in1[g] + o_in2[g];
      assign alu_f[g] = (o_in1[g] == o_in2[g]);
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // Transaction view: phase 0 waiting, 1 operation in flight, 2 result offered.
   typedef struct {
      int          phase;
      int          owner;
      int          last;
      logic [31:0] a, b;
      logic [3:0]  cmd;
      logic [1:0]  op;
      logic        br;
      logic [31:0] rd;
      logic        rf;
   } mdl_t;

   mdl_t m [2];
   logic took0, took1;

   function automatic mdl_t mdl_reset();
      mdl_t r;
      r.phase = 0; r.owner = 0; r.last = 1;
      r.a = '0; r.b = '0; r.cmd = '0; r.op = '0; r.br = 1'b0;
      r.rd = '0; r.rf = 1'b0;
      return r;
   endfunction

   always @(negedge clk) begin
      int w;
      logic done;
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) m[i] = mdl_reset();
         w = -1;
         if (v0 && v1)      w = (i == 1) ? 0 : (m[i].last == 0 ? 1 : 0);
         else if (v0)       w = 0;
         else if (v1)       w = 1;
         if (!rst_n || m[i].phase != 0) w = -1;
         chk($sformatf("u%0d req0_ready", i), o_rdy0[i], w == 0);
         chk($sformatf("u%0d req1_ready", i), o_rdy1[i], w == 1);
         chk($sformatf("u%0d rsp0_valid", i), o_rv0[i], m[i].phase == 2 && m[i].owner == 0);
         chk($sformatf("u%0d rsp1_valid", i), o_rv1[i], m[i].phase == 2 && m[i].owner == 1);
         chk($sformatf("u%0d rsp0_data", i), o_rd0[i], m[i].rd);
         chk($sformatf("u%0d rsp1_data", i), o_rd1[i], m[i].rd);
         chk($sformatf("u%0d rsp0_flag", i), o_rf0[i], m[i].rf);
         chk($sformatf("u%0d rsp1_flag", i), o_rf1[i], m[i].rf);
         chk($sformatf("u%0d alu_in1", i), o_in1[i], m[i].a);
         chk($sformatf("u%0d alu_in2", i), o_in2[i], m[i].b);
         chk($sformatf("u%0d alu_ex_cmd", i), o_cmd[i], m[i].cmd);
         chk($sformatf("u%0d alu_aluop", i), o_op[i], m[i].op);
         chk($sformatf("u%0d alu_branchD", i), o_br[i], m[i].br);
         chk($sformatf("u%0d busy", i), o_busy[i], m[i].phase != 0);
         if (i == 0) begin
            took0 = (w == 0);
            took1 = (w == 1);
         end
         if (rst_n) begin
            if (m[i].phase == 0 && w == 0) begin
               m[i].a = a0; m[i].b = b0; m[i].cmd = c0; m[i].op = op0; m[i].br = br0;
               m[i].owner = 0; m[i].last = 0; m[i].phase = 1;
            end else if (m[i].phase == 0 && w == 1) begin
               m[i].a = a1; m[i].b = b1; m[i].cmd = c1; m[i].op = op1; m[i].br = br1;
               m[i].owner = 1; m[i].last = 1; m[i].phase = 1;
            end else if (m[i].phase == 1) begin
               m[i].rd = m[i].a + m[i].b;
               m[i].rf = (m[i].a == m[i].b);
               m[i].phase = 2;
            end else if (m[i].phase == 2) begin
               done = (m[i].owner == 0) ? rr0 : rr1;
               if (done) m[i].phase = 0;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (o_busy != 2'b00 && n < 20) begin
         step();
         n++;
      end
      chk("wait_idle", {31'b0, o_busy == 2'b00}, 1);
   endtask

   int gq0[$], tq0[$], gq1[$];
   int exp_rr[4] = '{0, 1, 0, 1};
   int cnt;

   initial begin
      rst_n = 1'b0;
      v0 = 0; v1 = 0; br0 = 0; br1 = 0; rr0 = 0; rr1 = 0;
      a0 = 0; b0 = 0; a1 = 0; b1 = 0; c0 = 0; c1 = 0; op0 = 0; op1 = 0;
      took0 = 0; took1 = 0;
      repeat (3) step();
      rst_n = 1'b1;
      step();

      // Single operation with immediate response acceptance.
      v0 = 1; a0 = 88; b0 = 88; c0 = 4'b1111; op0 = 2'd1; br0 = 0; rr0 = 1;
      #1 chk("t033 req0_ready at T", o_rdy0[0], 1);
      step();
      v0 = 0;
      chk("t033 alu_in1 at T+1", o_in1[0], 88);
      chk("t033 alu_ex_cmd at T+1", o_cmd[0], 4'b1111);
      step();
      chk("t033 rsp0_valid at T+2", o_rv0[0], 1);
      chk("t033 rsp0_data at T+2", o_rd0[0], 176);
      chk("t033 rsp0_flag at T+2", o_rf0[0], 1);
      step();
      chk("t033 busy at T+3", o_busy[0], 0);
      chk("t033 rsp0_valid at T+3", o_rv0[0], 0);

      // Both requesters continuously valid from a fresh reset.
      rst_n = 0;
      step();
      rst_n = 1; v0 = 1; v1 = 1; a0 = 3; b0 = 4; a1 = 10; b1 = 10; rr0 = 1; rr1 = 1;
      for (int c = 0; c < 12; c++) begin
         #1;
         if (o_rdy0[0]) begin gq0.push_back(0); tq0.push_back(c); end
         if (o_rdy1[0]) begin gq0.push_back(1); tq0.push_back(c); end
         if (o_rdy0[1]) gq1.push_back(0);
         if (o_rdy1[1]) gq1.push_back(1);
         step();
      end
      v0 = 0; v1 = 0;
      chk("t034 rr grant count", gq0.size(), 4);
      chk("t034 fixed grant count", gq1.size(), 4);
      if (gq0.size() == 4 && gq1.size() == 4)
         for (int k = 0; k < 4; k++) begin
            chk($sformatf("t034 rr grant %0d", k), gq0[k], exp_rr[k]);
            chk($sformatf("t034 fixed grant %0d", k), gq1[k], 0);
            if (k > 0) chk($sformatf("t034 grant spacing %0d", k), tq0[k] - tq0[k-1], 3);
         end
      wait_idle();

      // Stalled response for requester 1 while requester 0 waits.
      v1 = 1; a1 = 5; b1 = 7; c1 = 4'd2; op1 = 2'd0; br1 = 1; rr0 = 0; rr1 = 0;
      #1 chk("t035 req1_ready", o_rdy1[0], 1);
      step();
      v1 = 0; v0 = 1; a0 = 1; b0 = 2; c0 = 4'd3; op0 = 2'd2; br0 = 0;
      cnt = 0;
      for (int c = 0; c < 6; c++) begin
         chk($sformatf("t035 req0 blocked %0d", c), o_rdy0[0], 0);
         if (o_rv1[0]) begin
            cnt++;
            chk("t035 rsp1_data", o_rd1[0], 12);
            chk("t035 rsp1_flag", o_rf1[0], 0);
         end
         step();
      end
      chk("t035 rsp1_valid cycles", cnt, 5);
      rr1 = 1;
      step();
      rr1 = 0;
      chk("t035 req0 accepted after idle", o_rdy0[0], 1);

      // Non-owner response ready must not disturb requester 0's result.
      step();
      v0 = 0;
      step();
      for (int c = 0; c < 4; c++) begin
         rr1 = ~rr1;
         step();
         chk("t037 rsp0_valid held", o_rv0[0], 1);
         chk("t037 rsp0_data held", o_rd0[0], 3);
         chk("t037 rsp1_valid low", o_rv1[0], 0);
      end
      rr0 = 1; rr1 = 0;
      step();
      chk("t037 idle after rsp0_ready", o_busy[0], 0);

      // Reset pulse while an operation is executing.
      wait_idle();
      v0 = 1; a0 = 9; b0 = 9;
      step();
      rst_n = 0; v1 = 1;
      #1;
      chk("t036 req0_ready in reset", o_rdy0[0], 0);
      chk("t036 req1_ready in reset", o_rdy1[0], 0);
      chk("t036 busy in reset", o_busy[0], 0);
      chk("t036 alu_in1 in reset", o_in1[0], 0);
      chk("t036 rsp0_valid in reset", o_rv0[0], 0);
      step();
      rst_n = 1;
      #1 chk("t036 first grant after reset", o_rdy0[0], 1);
      chk("t036 no req1 grant after reset", o_rdy1[0], 0);
      step();
      v0 = 0; v1 = 0;
      wait_idle();

      // Randomized traffic; a requester only changes its request once taken or idle.
      for (int c = 0; c < 3000; c++) begin
         if (!v0 || took0) begin
            v0  = ($urandom_range(0, 2) != 0);
            a0  = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 3));
            b0  = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 3));
            c0  = 4'($urandom); op0 = 2'($urandom); br0 = 1'($urandom);
         end
         if (!v1 || took1) begin
            v1  = ($urandom_range(0, 2) != 0);
            a1  = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 3));
            b1  = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 3));
            c1  = 4'($urandom); op1 = 2'($urandom); br1 = 1'($urandom);
         end
         rr0   = 1'($urandom);
         rr1   = 1'($urandom);
         rst_n = ($urandom_range(0, 249) != 0);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter FIXED_PRI, default 0, meaning: 0 = round-robin arbitration; 1 = requester 0 always wins.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 reqN_valid  in  1  requester N (N=0,1) presents an operation.
REQ-005 reqN_ready  out  1  requester N operation accepted this cycle.
REQ-006 reqN_a, reqN_b  in  32 each  requester N operands.
REQ-007 reqN_cmd  in  4  ex_cmd for requester N.
REQ-008 reqN_aluop  in  2  ALUOp for requester N.
REQ-009 reqN_branch  in  1  branchD for requester N.
REQ-010 rspN_valid  out  1  result for requester N available.
REQ-011 rspN_ready  in  1  requester N takes the result.
REQ-012 rspN_data  out  32; rspN_flag  out  1  captured alu_out / flag.
REQ-013 alu_in1, alu_in2  out  32 each; alu_ex_cmd  out  4; alu_aluop  out  2; alu_branchD  out  1  drive shared ALU.
REQ-014 alu_out  in  32; alu_flag  in  1  combinational ALU result.
REQ-015 busy  out  1  high in any state other than IDLE.

Function
REQ-016 FSM states IDLE, EXEC, RESP.
REQ-017 IDLE: if any reqN_valid, pick winner, assert its reqN_ready combinationally, latch winner operands/cmd/aluop/branch and owner id into operand registers, go EXEC.
REQ-018 reqN_ready SHALL be high only in IDLE, only for the winner, never for both requesters.
REQ-019 Single valid requester wins unconditionally.
REQ-020 Both valid, FIXED_PRI=0: grant the requester not equal to last_grant; FIXED_PRI=1: grant requester 0.
REQ-021 last_grant updates to the winner on every accept.
REQ-022 alu_* outputs SHALL always be driven from operand registers, stable through EXEC and RESP.
REQ-023 EXEC: capture alu_out, alu_flag into result registers, go RESP; lasts exactly one cycle.
REQ-024 RESP: rspN_valid high for owner only; data/flag held stable until rspN_ready.
REQ-025 RESP with rspN_ready high: return to IDLE next cycle; rspN_valid deasserts that edge.
REQ-026 Latency: accept at cycle T -> rsp valid at T+2 (zero backpressure); min 3 cycles per operation.
REQ-027 Requests arriving in EXEC/RESP are not accepted; requester holds valid and operands until ready.
REQ-028 rspN_ready of the non-owner, or when rspN_valid low, SHALL be ignored.
REQ-029 Operand registers retain last values in IDLE; no arithmetic performed in this block.

Reset
REQ-030 rst_n low: state=IDLE, last_grant=1, operand/result registers=0, owner=0, all ready/valid outputs=0, busy=0, alu_* outputs=0.
REQ-031 Reset mid-operation (EXEC or RESP) SHALL drop the transaction; no rsp issued after release.
REQ-032 First arbitration after reset with both valid grants requester 0 (FIXED_PRI=0).

Verification (bench ALU stub: alu_out=in1+in2, alu_flag=(in1==in2))
REQ-033 req0 a=88 b=88 cmd=4'b1111 aluop=1 branch=0, rsp0_ready=1 -> req0_ready at T; alu_in1=88, alu_ex_cmd=4'b1111 at T+1; rsp0_valid, rsp0_data=176, rsp0_flag=1 at T+2; idle at T+3.
REQ-034 Both valid continuously, FIXED_PRI=0, ready held high -> grants 0,1,0,1 every 3 cycles; FIXED_PRI=1 -> grants 0 only.
REQ-035 req1 a=5 b=7, rsp1_ready low 4 cycles -> rsp1_valid held 4+ cycles with data=12 flag=0; req0 asserted meanwhile gets no ready until IDLE.
REQ-036 rst_n pulsed low during EXEC -> all outputs 0 asynchronously; no rspN_valid after release; next both-valid grant goes to 0.
REQ-037 rsp1_ready toggled while owner is 0 -> no state change; rsp0 stays valid.
